// File: rtl/wb_bram_ctrl.sv
// Wishbone classic slave bridging a decoded address window onto a single-port BRAM.
// Optional WB_BRAM_BOUND_EN: acks out-of-range window accesses (reads return all ones).
module wb_bram_ctrl #(
  parameter logic [31:0] ADDR_BASE   = 32'h3800_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          DELAYS      = 10
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        bram_en,
  output logic [3:0]  bram_we,
  output logic [31:0] bram_addr,
  output logic [31:0] bram_di,
  input  logic [31:0] bram_do,
  output logic        busy_o
);

  localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);
  localparam logic [7:0]  LAST  = 8'(DELAYS - 2);
  localparam logic [7:0]  PRE   = 8'(DELAYS - 3);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [15:0] off_q;
  logic [31:0] di_q;
  logic        we_q;
  logic        oor_q;
  logic        rd_ack;
  logic        region;
  logic        inrange;
  logic        accept;

  assign region  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:16] == ADDR_BASE[31:16]);
  assign inrange = {16'h0, wbs_adr_i[15:0]} < LIMIT;
`ifdef WB_BRAM_BOUND_EN
  assign accept  = region;
`else
  assign accept  = region & inrange;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      cnt       <= 8'd0;
      off_q     <= 16'h0;
      di_q      <= 32'h0;
      we_q      <= 1'b0;
      oor_q     <= 1'b0;
      rd_ack    <= 1'b0;
      wbs_ack_o <= 1'b0;
      bram_en   <= 1'b0;
      bram_we   <= 4'h0;
    end else begin
      bram_en   <= 1'b0;
      bram_we   <= 4'h0;
      wbs_ack_o <= 1'b0;
      rd_ack    <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          state <= S_WAIT;
          cnt   <= 8'd0;
          off_q <= wbs_adr_i[15:0];
          di_q  <= wbs_dat_i;
          we_q  <= wbs_we_i;
          oor_q <= ~inrange;
          // First WAIT cycle carries the write; with DELAYS=2 it is also the read slot.
          bram_en <= inrange & (wbs_we_i | (DELAYS == 2));
          bram_we <= (wbs_we_i & inrange) ? wbs_sel_i : 4'h0;
        end
        S_WAIT: begin
          if (!(wbs_cyc_i & wbs_stb_i)) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
            if (cnt == LAST) begin
              state     <= S_ACK;
              wbs_ack_o <= 1'b1;
              rd_ack    <= ~we_q;
            end else if (cnt == PRE && !we_q && !oor_q) begin
              bram_en <= 1'b1;
            end
          end
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // bram_do is the BRAM's own output register, so gating it with registered state keeps
  // wbs_dat_o edge-aligned and zero outside the read ack cycle.
  assign wbs_dat_o = rd_ack ? (oor_q ? 32'hFFFF_FFFF : bram_do) : 32'h0;
  assign bram_addr = {16'h0, off_q};
  assign bram_di   = di_q;
  assign busy_o    = (state != S_IDLE);

endmodule
